fml_ddr3_ctlif: RTL and testbench

- Bridges a 64-bit FML (Fast Memory Link) slave port to a Xilinx MIG-style DDR3 user (app_*) interface.
- Each 4-beat FML burst (4 x 64 bits) maps to exactly one 256-bit MIG read or write transaction.
- The block holds a 4-entry read buffer and a 4-entry write buffer. It sits between the FML arbiter and the DDR3 memory controller core.

---
 rtl/fml_ddr3_ctlif.sv | 191 +++++++++++++++++++
 tb/tb_fml_ddr3_ctlif.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fml_ddr3_ctlif.sv
// FML (4 x 64-bit burst) to MIG DDR3 app_* bridge: one 256-bit MIG transaction per FML burst.
// Define FML_DDR3_CTLIF_WMASK_EN for byte-granular writes driven by fml_sel; otherwise writes are full-width.
module fml_ddr3_ctlif #(
  parameter int adr_width      = 30,
  parameter int APP_ADDR_WIDTH = 27,
  parameter int APP_DATA_WIDTH = 256,
  parameter int APP_MASK_WIDTH = APP_DATA_WIDTH / 8
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [adr_width-1:0]      fml_adr,
  input  logic                      fml_stb,
  input  logic                      fml_we,
  output logic                      fml_ack,
  input  logic [7:0]                fml_sel,
  input  logic [63:0]               fml_di,
  output logic [63:0]               fml_do,
  input  logic                      app_rdy,
  input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
  input  logic                      app_rd_data_end,
  input  logic                      app_rd_data_valid,
  input  logic                      app_wdf_rdy,
  output logic [APP_ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]                app_cmd,
  output logic                      app_en,
  output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
  output logic                      app_wdf_end,
  output logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
  output logic                      app_wdf_wren
);
  localparam int NUM_LANES = APP_DATA_WIDTH / 64;
  localparam int CW        = $clog2(NUM_LANES);
  localparam logic [CW-1:0] LAST = CW'(NUM_LANES - 1);
  localparam logic [2:0] CMD_RD = 3'b001;
  localparam logic [2:0] CMD_WR = 3'b000;

  typedef enum logic [3:0] {
    IDLE, RD_CMD, RD_WAIT, RD_ACK, RD_OUT, WR_ACK, WR_COLLECT, WR_DATA, WR_CMD
  } state_t;

  state_t                           state_q, state_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic                             ack_q, ack_d;
  logic [63:0]                      do_q, do_d;
  logic                             en_q, en_d;
  logic [2:0]                       cmd_q, cmd_d;
  logic [APP_ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic                             wren_q, wren_d;
  logic [APP_DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic [APP_MASK_WIDTH-1:0]        wmask_q, wmask_d;
  logic [NUM_LANES-1:0][63:0]       rbuf_q, rbuf_d;
  logic [NUM_LANES-1:0][63:0]       wbuf_q, wbuf_d;
`ifdef FML_DDR3_CTLIF_WMASK_EN
  logic [NUM_LANES-1:0][7:0]        sbuf_q, sbuf_d;
  logic                             unused_ok;
  assign unused_ok = ^{app_rd_data_end, fml_adr[4:0]};
`else
  logic                             unused_ok;
  assign unused_ok = ^{app_rd_data_end, fml_adr[4:0], fml_sel};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    do_d    = do_q;
    en_d    = en_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wren_d  = wren_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rbuf_d  = rbuf_q;
    wbuf_d  = wbuf_q;
`ifdef FML_DDR3_CTLIF_WMASK_EN
    sbuf_d  = sbuf_q;
`endif
    case (state_q)
      IDLE: if (fml_stb) begin
        addr_d = APP_ADDR_WIDTH'({fml_adr[adr_width-1:5], 2'b00});
        cnt_d  = '0;
        if (fml_we) begin
          state_d = WR_ACK;
          ack_d   = 1'b1;
        end else begin
          state_d = RD_CMD;
          en_d    = 1'b1;
          cmd_d   = CMD_RD;
        end
      end
      RD_CMD: if (app_rdy) begin
        en_d    = 1'b0;
        state_d = RD_WAIT;
      end
      RD_WAIT: if (app_rd_data_valid) begin
        rbuf_d  = app_rd_data;
        ack_d   = 1'b1;
        state_d = RD_ACK;
      end
      RD_ACK: begin
        do_d    = rbuf_q[0];
        cnt_d   = CW'(1);
        state_d = RD_OUT;
      end
      RD_OUT: begin
        do_d  = rbuf_q[cnt_q];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = IDLE;
      end
      WR_ACK: begin
        cnt_d   = '0;
        state_d = WR_COLLECT;
      end
      WR_COLLECT: begin
        wbuf_d[cnt_q] = fml_di;
`ifdef FML_DDR3_CTLIF_WMASK_EN
        sbuf_d[cnt_q] = fml_sel;
`endif
        cnt_d = cnt_q + 1'b1;
        // Last beat goes straight into the write-data register, skipping a buffer cycle.
        if (cnt_q == LAST) begin
          state_d = WR_DATA;
          wren_d  = 1'b1;
          wdata_d = wbuf_d;
`ifdef FML_DDR3_CTLIF_WMASK_EN
          for (int k = 0; k < NUM_LANES; k++) wmask_d[8*k +: 8] = ~sbuf_d[k];
`else
          wmask_d = '0;
`endif
        end
      end
      WR_DATA: if (app_wdf_rdy) begin
        wren_d  = 1'b0;
        en_d    = 1'b1;
        cmd_d   = CMD_WR;
        state_d = WR_CMD;
      end
      WR_CMD: if (app_rdy) begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      do_q    <= '0;
      en_q    <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
      wren_q  <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rbuf_q  <= '0;
      wbuf_q  <= '0;
`ifdef FML_DDR3_CTLIF_WMASK_EN
      sbuf_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      do_q    <= do_d;
      en_q    <= en_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wren_q  <= wren_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rbuf_q  <= rbuf_d;
      wbuf_q  <= wbuf_d;
`ifdef FML_DDR3_CTLIF_WMASK_EN
      sbuf_q  <= sbuf_d;
`endif
    end
  end

  assign fml_ack      = ack_q;
  assign fml_do       = do_q;
  assign app_en       = en_q;
  assign app_cmd      = cmd_q;
  assign app_addr     = addr_q;
  assign app_wdf_wren = wren_q;
  assign app_wdf_end  = wren_q;
  assign app_wdf_data = wdata_q;
  assign app_wdf_mask = wmask_q;
endmodule

// File: tb/tb_fml_ddr3_ctlif.sv
// Scoreboard bench for fml_ddr3_ctlif: expected MIG commands, write data and FML read beats are
// queued at stimulus time and checked when the DUT produces them.
module tb_fml_ddr3_ctlif;
  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic [29:0]   fml_adr;
  logic          fml_stb, fml_we, fml_ack;
  logic [7:0]    fml_sel;
  logic [63:0]   fml_di, fml_do;
  logic          app_rdy, app_rd_data_end, app_rd_data_valid, app_wdf_rdy;
  logic [255:0]  app_rd_data;
  logic [26:0]   app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_wdf_end, app_wdf_wren;
  logic [255:0]  app_wdf_data;
  logic [31:0]   app_wdf_mask;

  int n_cmp = 0;
  int n_bad = 0;

  logic [29:0]  exp_cmd_q[$];
  logic [63:0]  exp_do_q[$];
  logic [287:0] exp_wdf_q[$];

  fml_ddr3_ctlif dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we), .fml_ack(fml_ack),
    .fml_sel(fml_sel), .fml_di(fml_di), .fml_do(fml_do),
    .app_rdy(app_rdy), .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end),
    .app_rd_data_valid(app_rd_data_valid), .app_wdf_rdy(app_wdf_rdy),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] map_addr(input logic [29:0] a);
    return {a[29:5], 2'b00};
  endfunction

  function automatic logic [31:0] exp_mask(input logic [3:0][7:0] sel);
    logic [31:0] m;
    m = '0;
`ifdef FML_DDR3_CTLIF_WMASK_EN
    for (int k = 0; k < 4; k++) m[8*k +: 8] = ~sel[k];
`endif
    return m;
  endfunction

  // MIG-side monitors: commands and write data, checked on acceptance.
  always @(negedge sys_clk) begin
    if (!sys_rst && app_en && app_rdy) begin
      if (exp_cmd_q.size() == 0) chk("cmd_unexpected", 1'b1, 1'b0);
      else begin
        logic [29:0] e;
        e = exp_cmd_q.pop_front();
        chk("app_addr", app_addr, e[29:3]);
        chk("app_cmd", app_cmd, e[2:0]);
      end
    end
    if (!sys_rst && app_wdf_wren && app_wdf_rdy) begin
      if (exp_wdf_q.size() == 0) chk("wdf_unexpected", 1'b1, 1'b0);
      else begin
        logic [287:0] e;
        e = exp_wdf_q.pop_front();
        chk("wdf_data", app_wdf_data, e[287:32]);
        chk("wdf_mask", app_wdf_mask, e[31:0]);
        chk("wdf_end", app_wdf_end, 1'b1);
      end
    end
    if (app_en && app_wdf_wren) chk("en_during_wdf", 1'b1, 1'b0);
  end

  task automatic do_read(input logic [29:0] adr, input logic [3:0][63:0] d, input int stall);
    int stalled, dly;
    bit got_ack, rd_given, jphase, pre_acc, pre_stall;
    exp_cmd_q.push_back({map_addr(adr), 3'b001});
    for (int k = 0; k < 4; k++) exp_do_q.push_back(d[k]);
    stalled = 0; dly = 0; got_ack = 0; rd_given = 0; jphase = 1;
    fml_adr = adr; fml_we = 1'b0; fml_stb = 1'b1;
    app_rdy = (stall == 0);
    app_rd_data = ~d;               // junk valid data before the command is accepted
    app_rd_data_valid = 1'b1;
    for (int c = 0; c < 200 && !got_ack; c++) begin
      pre_acc   = app_en && app_rdy;
      pre_stall = app_en && !app_rdy;
      @(posedge sys_clk); #1;
      app_rd_data_valid = 1'b0;
      if (pre_stall) begin
        stalled++;
        if (stalled >= stall) app_rdy = 1'b1;
      end
      if (pre_acc) begin jphase = 0; dly = 2; end
      else if (dly > 0) begin
        dly--;
        if (dly == 0) begin app_rd_data = d; app_rd_data_valid = 1'b1; rd_given = 1; end
      end
      if (jphase) app_rd_data_valid = 1'b1;
      if (fml_ack) got_ack = 1;
    end
    app_rd_data_valid = 1'b0;
    if (!got_ack) begin
      chk("rd_ack_timeout", 1'b0, 1'b1);
      exp_do_q.delete();
      fml_stb = 1'b0;
      return;
    end
    chk("rd_ack_after_data", rd_given, 1'b1);
    if (stall > 0) chk("rd_en_stall_cycles", stalled, stall);
    fml_stb = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge sys_clk); #1;
      if (k == 0) chk("rd_ack_one_cycle", fml_ack, 1'b0);
      chk("fml_do", fml_do, exp_do_q.pop_front());
    end
  endtask

  task automatic do_write(input logic [29:0] adr, input logic [3:0][63:0] d,
                          input logic [3:0][7:0] sel, input int wstall);
    int stalled;
    bit got_ack, done, pre_acc, pre_stall;
    exp_wdf_q.push_back({d, exp_mask(sel)});
    exp_cmd_q.push_back({map_addr(adr), 3'b000});
    stalled = 0; got_ack = 0; done = 0;
    fml_adr = adr; fml_we = 1'b1; fml_stb = 1'b1;
    app_rdy = 1'b1; app_wdf_rdy = (wstall == 0);
    for (int c = 0; c < 50 && !got_ack; c++) begin
      @(posedge sys_clk); #1;
      if (fml_ack) got_ack = 1;
    end
    fml_stb = 1'b0;
    if (!got_ack) begin chk("wr_ack_timeout", 1'b0, 1'b1); return; end
    for (int k = 0; k < 4; k++) begin
      @(posedge sys_clk); #1;
      if (k == 0) chk("wr_ack_one_cycle", fml_ack, 1'b0);
      fml_di = d[k]; fml_sel = sel[k];
    end
    for (int c = 0; c < 100 && !done; c++) begin
      pre_acc   = app_en && app_rdy;
      pre_stall = app_wdf_wren && !app_wdf_rdy;
      @(posedge sys_clk); #1;
      fml_di = 64'hdead_beef_dead_beef; fml_sel = 8'h00;
      if (pre_stall) begin
        stalled++;
        if (stalled >= wstall) app_wdf_rdy = 1'b1;
      end
      if (pre_acc) done = 1;
    end
    if (!done) chk("wr_done_timeout", 1'b0, 1'b1);
    if (wstall > 0) chk("wren_stall_cycles", stalled, wstall);
  endtask

  initial begin
    logic [3:0][63:0] d;
    logic [3:0][7:0]  s;
    sys_rst = 1'b1; fml_adr = '0; fml_stb = 1'b0; fml_we = 1'b0; fml_sel = '0; fml_di = '0;
    app_rdy = 1'b1; app_rd_data = '0; app_rd_data_end = 1'b0; app_rd_data_valid = 1'b0;
    app_wdf_rdy = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_outputs", {fml_ack, fml_do, app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
                        app_wdf_mask}, '0);
    chk("rst_wdf_data", app_wdf_data, '0);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    d = {64'haaaa_aaaa_aaaa_aaaa, 64'hbbbb_bbbb_bbbb_bbbb, 64'hcccc_cccc_cccc_cccc, 64'hdddd_dddd_dddd_dddd};
    do_read(30'h0000040, d, 0);
    d = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    s = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_write(30'h0000020, d, s, 0);
    s = {8'hFF, 8'hFF, 8'h0F, 8'hFF};
    do_write(30'h0000060, d, s, 0);
    d = {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210, 64'h5a5a_5a5a_a5a5_a5a5, 64'h0f0f_f0f0_0f0f_f0f0};
    do_read(30'h000005F, d, 5);                        // low address bits ignored, rdy stall
    s = {8'h81, 8'h00, 8'h3C, 8'hFE};
    do_write(30'h3FFFFFE0, d, s, 3);                   // top address, wdf_rdy stall
    do_read(30'h3FFFFFFF, ~d, 0);

    // Reset while waiting for read data.
    exp_cmd_q.push_back({map_addr(30'h0000100), 3'b001});
    fml_adr = 30'h0000100; fml_we = 1'b0; fml_stb = 1'b1; app_rdy = 1'b1;
    for (int c = 0; c < 20 && !(app_en && app_rdy); c++) begin @(posedge sys_clk); #1; end
    @(posedge sys_clk); #1;
    sys_rst = 1'b1; fml_stb = 1'b0;
    @(posedge sys_clk); #1;
    chk("midrst_outputs", {fml_ack, fml_do, app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
                           app_wdf_mask}, '0);
    sys_rst = 1'b0;
    app_rd_data_valid = 1'b1;                          // stale data after reset must be ignored
    @(posedge sys_clk); #1;
    app_rd_data_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        d[k] = {$urandom, $urandom};
        s[k] = 8'($urandom);
      end
      if (i[0]) do_write(30'($urandom), d, s, i);
      else      do_read(30'($urandom), d, i);
    end
    repeat (3) @(posedge sys_clk);
    #1;
    chk("cmd_q_empty", exp_cmd_q.size(), 0);
    chk("wdf_q_empty", exp_wdf_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
